// File: rtl/tile_pkg.sv
// Shared tile definitions for the board controller and renderer.
// Tile byte layout: [7:2] RGB colour, [1:0] tile state.
package tile_pkg;

  localparam int NUM_TILES = 16;
  localparam int NUM_PAIRS = 8;

  localparam logic [1:0] ST_MATCHED = 2'b00;
  localparam logic [1:0] ST_HIDDEN  = 2'b01;
  localparam logic [1:0] ST_FACEUP  = 2'b10;

  typedef enum logic [2:0] {
    S_INIT,
    S_FIRST,
    S_SECOND,
    S_COMPARE,
    S_SHOW,
    S_RESOLVE,
    S_DONE
  } boardState_t;

  localparam logic [5:0] PALETTE [0:7] = '{
    6'h03, 6'h0C, 6'h30, 6'h0F,
    6'h33, 6'h3C, 6'h15, 6'h2A
  };

  // Initial byte for a tile: seed-scrambled colour, hidden.
  function automatic logic [7:0] layoutByte(
    input logic [3:0] idx,
    input logic [3:0] seedKey
  );
    logic [3:0] p;
    p = idx ^ seedKey;
    return {PALETTE[p[3:1]], ST_HIDDEN};
  endfunction

endpackage

// File: rtl/tile_frame_timer.sv
// Counts frame ticks while enabled; done pulses on the
// DISPLAY_FRAMES-th counted tick.
module tile_frame_timer #(
  parameter int DISPLAY_FRAMES = 60
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic done
);

  localparam logic [7:0] LAST = 8'(DISPLAY_FRAMES - 1);

  logic [7:0] cnt;

  assign done = enable & tick & (cnt == LAST);

  // Tick counter, restarted by clear or on completion.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cnt <= '0;
    end else if (enable && tick) begin
      cnt <= done ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/tile_board_controller.sv
// Game-state engine for the 4x4 tile-matching board:
// tile memory, selection sequencing and match/move counts.
module tile_board_controller
  import tile_pkg::*;
#(
  parameter int DISPLAY_FRAMES = 60
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       new_game,
  input  logic [3:0] seed,
  input  logic       sel_valid,
  input  logic [3:0] sel_idx,
  input  logic [3:0] disp_addr,
  output logic [7:0] disp_data,
  output logic [3:0] match_count,
  output logic [7:0] move_count,
  output logic       busy,
  output logic       game_over
);

  boardState_t state;
  logic [7:0]  mem [NUM_TILES];
  logic [3:0]  initIdx;
  logic [3:0]  seedQ;
  logic [3:0]  aIdx;
  logic [3:0]  bIdx;
  logic        matchQ;
  logic [3:0]  matchCount;
  logic [7:0]  moveCount;
  logic        timerDone;
  logic        selOk;
  logic        initWr;
  logic        resWr;
  logic [1:0]  resState;

  assign disp_data   = mem[disp_addr];
  assign match_count = matchCount;
  assign move_count  = moveCount;
  assign busy        = !(state == S_FIRST || state == S_SECOND);
  assign game_over   = (state == S_DONE);

  // A selection lands only on a hidden tile while waiting for one.
  assign selOk = sel_valid && !new_game && !busy
              && (mem[sel_idx][1:0] == ST_HIDDEN);

  assign initWr   = (state == S_INIT);
  assign resWr    = (state == S_RESOLVE) && !new_game;
  assign resState = matchQ ? ST_MATCHED : ST_HIDDEN;

  tile_frame_timer #(
    .DISPLAY_FRAMES(DISPLAY_FRAMES)
  ) uTimer (
    .clk   (clk),
    .resetn(resetn),
    .clear (new_game || state == S_COMPARE),
    .enable(state == S_SHOW && !new_game),
    .tick  (frame_tick),
    .done  (timerDone)
  );

  // Tile memory; resolve writes only the state bits of A and B.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TILES; i++) begin
      if (!resetn) begin
        mem[i] <= {6'd0, ST_HIDDEN};
      end else if (initWr && initIdx == 4'(i)) begin
        mem[i] <= layoutByte(4'(i), seedQ);
      end else if (resWr && (aIdx == 4'(i) || bIdx == 4'(i))) begin
        mem[i][1:0] <= resState;
      end else if (selOk && sel_idx == 4'(i)) begin
        mem[i][1:0] <= ST_FACEUP;
      end
    end
  end

  // Game sequencer and counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_INIT;
      initIdx    <= '0;
      seedQ      <= '0;
      aIdx       <= '0;
      bIdx       <= '0;
      matchQ     <= 1'b0;
      matchCount <= '0;
      moveCount  <= '0;
    end else if (new_game) begin
      state      <= S_INIT;
      initIdx    <= '0;
      seedQ      <= seed;
      matchCount <= '0;
      moveCount  <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          initIdx <= initIdx + 4'd1;
          if (initIdx == 4'd15) state <= S_FIRST;
        end
        S_FIRST: begin
          if (selOk) begin
            aIdx  <= sel_idx;
            state <= S_SECOND;
          end
        end
        S_SECOND: begin
          if (selOk) begin
            bIdx  <= sel_idx;
            state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          matchQ <= (mem[aIdx][7:2] == mem[bIdx][7:2]);
          if (moveCount != 8'hFF) moveCount <= moveCount + 8'd1;
          state <= S_SHOW;
        end
        S_SHOW: begin
          if (timerDone) state <= S_RESOLVE;
        end
        S_RESOLVE: begin
          if (matchQ) begin
            matchCount <= matchCount + 4'd1;
            state <= (matchCount == 4'(NUM_PAIRS - 1)) ? S_DONE : S_FIRST;
          end else begin
            state <= S_FIRST;
          end
        end
        S_DONE: state <= S_DONE;
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_board_controller.sv
// Scoreboard bench for tile_board_controller.
// Board model predicts every tile byte after each action.
`timescale 1ns/1ps
module tb_tile_board_controller;
  import tile_pkg::*;

  localparam int DF = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic       new_game;
  logic [3:0] seed;
  logic       sel_valid;
  logic [3:0] sel_idx;
  logic [3:0] disp_addr;
  logic [7:0] disp_data;
  logic [3:0] match_count;
  logic [7:0] move_count;
  logic       busy;
  logic       game_over;

  int vecs = 0;
  int errs = 0;
  int expMove = 0;
  int expMatch = 0;

  typedef struct {
    string      tag;
    logic [3:0] addr;
    logic [7:0] val;
  } sb_t;

  sb_t        sbq[$];
  logic [7:0] model [16];

  tile_board_controller #(
    .DISPLAY_FRAMES(DF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .new_game   (new_game),
    .seed       (seed),
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .disp_addr  (disp_addr),
    .disp_data  (disp_data),
    .match_count(match_count),
    .move_count (move_count),
    .busy       (busy),
    .game_over  (game_over)
  );

  always #20 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic layout(logic [3:0] s);
    logic [3:0] x;
    for (int i = 0; i < 16; i++) begin
      x = 4'(i) ^ s;
      model[i] = {PALETTE[x[3:1]], 2'b01};
    end
  endtask

  // Push the expected board, then read each tile back.
  task automatic snap(string tag);
    sb_t e;
    for (int i = 0; i < 16; i++)
      sbq.push_back('{tag, 4'(i), model[i]});
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      disp_addr = e.addr;
      #1;
      chk($sformatf("%s[%0d]", e.tag, e.addr), disp_data, e.val);
    end
  endtask

  task automatic sel(logic [3:0] i);
    sel_valid = 1'b1;
    sel_idx   = i;
    cyc(1);
    sel_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  task automatic selTile(logic [3:0] i, bit acc, string tag);
    sel(i);
    if (acc) model[i][1:0] = 2'b10;
    snap(tag);
  endtask

  // From the COMPARE cycle through resolution.
  task automatic finishPair(logic [3:0] a, logic [3:0] b,
                            bit isMatch, int showSel);
    chk("busyCmp", busy, 1);
    tick();
    expMove = (expMove < 255) ? expMove + 1 : 255;
    chk("moveCmp", move_count, expMove);
    if (showSel >= 0) begin
      sel(4'(showSel));
      snap("showSel");
      chk("busyShow", busy, 1);
    end
    tick();
    snap("hold1");
    tick();
    snap("hold2");
    cyc(1);
    model[a][1:0] = isMatch ? 2'b00 : 2'b01;
    model[b][1:0] = isMatch ? 2'b00 : 2'b01;
    if (isMatch) expMatch++;
    snap("res");
    chk("matchRes", match_count, expMatch);
    chk("moveRes", move_count, expMove);
  endtask

  task automatic restart(logic [3:0] s);
    new_game = 1'b1;
    seed     = s;
    cyc(1);
    new_game = 1'b0;
    expMove  = 0;
    expMatch = 0;
    chk("ngBusy", busy, 1);
    chk("ngMove", move_count, 0);
    chk("ngMatch", match_count, 0);
    cyc(16);
    layout(s);
    snap("init");
    chk("initBusy", busy, 0);
  endtask

  initial begin
    resetn     = 1'b0;
    frame_tick = 1'b0;
    new_game   = 1'b0;
    seed       = 4'h0;
    sel_valid  = 1'b0;
    sel_idx    = 4'h0;
    disp_addr  = 4'h0;
    cyc(2);
    for (int i = 0; i < 16; i++) model[i] = 8'h01;
    chk("rstBusy", busy, 1);
    chk("rstOver", game_over, 0);
    chk("rstMatch", match_count, 0);
    chk("rstMove", move_count, 0);
    snap("rst");

    resetn = 1'b1;
    cyc(15);
    layout(4'h0);
    model[15] = 8'h01;
    snap("init15");
    chk("busy15", busy, 1);
    cyc(1);
    layout(4'h0);
    snap("init16");
    chk("busy16", busy, 0);
    chk("init0", model[0], {PALETTE[0], 2'b01});
    chk("init15v", model[15], {PALETTE[7], 2'b01});

    // Matching pair, with a selection attempted during SHOW.
    selTile(4'd0, 1, "selA");
    selTile(4'd1, 1, "selB");
    finishPair(4'd0, 4'd1, 1, 5);

    // Mismatching pair.
    selTile(4'd2, 1, "mmA");
    selTile(4'd4, 1, "mmB");
    finishPair(4'd2, 4'd4, 0, -1);

    // Reselect A and select a matched tile: both ignored.
    selTile(4'd2, 1, "ivA");
    selTile(4'd2, 0, "ivReA");
    chk("ivBusy1", busy, 0);
    selTile(4'd0, 0, "ivMatched");
    chk("ivBusy2", busy, 0);
    selTile(4'd3, 1, "ivB");
    finishPair(4'd2, 4'd3, 1, -1);

    // Full game with seed A.
    restart(4'hA);
    for (int p = 0; p < 8; p++) begin
      selTile(4'(2 * p), 1, "fgA");
      selTile(4'(2 * p + 1), 1, "fgB");
      finishPair(4'(2 * p), 4'(2 * p + 1), 1, -1);
    end
    chk("doneOver", game_over, 1);
    chk("doneMatch", match_count, 8);
    chk("doneBusy", busy, 1);
    selTile(4'd0, 0, "doneSel");
    chk("doneHold", game_over, 1);

    // new_game in the middle of SHOW, with a same-cycle tick.
    restart(4'h3);
    selTile(4'd0, 1, "ngA");
    selTile(4'd1, 1, "ngB");
    tick();
    chk("ngMove1", move_count, 1);
    tick();
    frame_tick = 1'b1;
    restart(4'h5);
    frame_tick = 1'b0;

    // Saturate move_count with mismatching attempts.
    for (int k = 0; k < 256; k++) begin
      sel(4'd0);
      sel(4'd2);
      tick();
      tick();
      tick();
      cyc(1);
    end
    chk("moveSat", move_count, 255);
    chk("matchSat", match_count, 0);
    snap("sat");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
